// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel PWM LED driver with double-buffered duty.
// Define LED_PWM_BREATHE_EN to add per-channel breathing and the MODE register.
module led_pwm_ctrl #(
    parameter int CHANNELS   = 3,
    parameter int PWM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_write,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic [CHANNELS-1:0]   pwm_out
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INVERT = ADDR_WIDTH'(2);

    function automatic logic [ADDR_WIDTH-1:0] duty_addr(input int n);
        return ADDR_WIDTH'(n + 3);
    endfunction

    logic                               enable, enable_nx;
    logic [15:0]                        prescale, prescale_nx;
    logic [CHANNELS-1:0]                invert, invert_nx;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] duty, duty_nx;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] shadow, level;
    logic [CHANNELS-1:0]                raw;
    logic [31:0]                        rdata_nx;
    logic [15:0]                        presc_cnt;
    logic [PWM_WIDTH-1:0]               pwm_cnt;
    logic                               tick, wrap;
    logic                               unused_wdata;

    assign unused_wdata = &{1'b0, bus_wdata};

    always_comb begin
        enable_nx   = enable;
        prescale_nx = prescale;
        invert_nx   = invert;
        duty_nx     = duty;
        if (bus_write) begin
            if (bus_address == ADDR_CTRL) begin
                enable_nx   = bus_wdata[0];
                prescale_nx = bus_wdata[31:16];
            end
            if (bus_address == ADDR_INVERT)
                invert_nx = bus_wdata[CHANNELS-1:0];
            for (int n = 0; n < CHANNELS; n++)
                if (bus_address == duty_addr(n))
                    duty_nx[n] = bus_wdata[PWM_WIDTH-1:0];
        end
    end

`ifdef LED_PWM_BREATHE_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_MODE = ADDR_WIDTH'(1);

    logic [CHANNELS-1:0]                mode, mode_nx;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] breathe_lvl, breathe_lvl_nx;
    logic [CHANNELS-1:0]                breathe_down, breathe_down_nx;

    always_comb begin
        mode_nx = mode;
        if (bus_write && bus_address == ADDR_MODE)
            mode_nx = bus_wdata[CHANNELS-1:0];
    end
`endif

    // Reads see this cycle's write so a same-cycle write/read returns new data.
    always_comb begin
        rdata_nx = '0;
        if (bus_address == ADDR_CTRL)
            rdata_nx = {prescale_nx, 15'd0, enable_nx};
        if (bus_address == ADDR_INVERT)
            rdata_nx[CHANNELS-1:0] = invert_nx;
`ifdef LED_PWM_BREATHE_EN
        if (bus_address == ADDR_MODE)
            rdata_nx[CHANNELS-1:0] = mode_nx;
`endif
        for (int n = 0; n < CHANNELS; n++)
            if (bus_address == duty_addr(n))
                rdata_nx[PWM_WIDTH-1:0] = duty_nx[n];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable    <= 1'b0;
            prescale  <= '0;
            invert    <= '0;
            duty      <= '0;
            bus_rdata <= '0;
        end else begin
            enable    <= enable_nx;
            prescale  <= prescale_nx;
            invert    <= invert_nx;
            duty      <= duty_nx;
            bus_rdata <= rdata_nx;
        end
    end

    assign tick = enable && (presc_cnt >= prescale);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            shadow    <= '0;
        end else begin
            if (!enable || tick)
                presc_cnt <= '0;
            else
                presc_cnt <= presc_cnt + 16'd1;
            if (!enable)
                pwm_cnt <= '0;
            else if (tick)
                pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            if (wrap)
                shadow <= duty;
        end
    end

`ifdef LED_PWM_BREATHE_EN
    // Triangle walk between 0 and shadow; a lowered shadow pulls level down.
    always_comb begin
        breathe_lvl_nx  = breathe_lvl;
        breathe_down_nx = breathe_down;
        for (int n = 0; n < CHANNELS; n++) begin
            if (!breathe_down[n] && breathe_lvl[n] < shadow[n])
                breathe_lvl_nx[n] = breathe_lvl[n] + PWM_WIDTH'(1);
            else if (breathe_lvl[n] != '0)
                breathe_lvl_nx[n] = breathe_lvl[n] - PWM_WIDTH'(1);
            if (breathe_lvl_nx[n] == '0)
                breathe_down_nx[n] = 1'b0;
            else if (breathe_lvl_nx[n] >= shadow[n])
                breathe_down_nx[n] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode         <= '0;
            breathe_lvl  <= '0;
            breathe_down <= '0;
        end else begin
            mode <= mode_nx;
            for (int n = 0; n < CHANNELS; n++) begin
                if (!enable || !mode[n]) begin
                    breathe_lvl[n]  <= '0;
                    breathe_down[n] <= 1'b0;
                end else if (wrap) begin
                    breathe_lvl[n]  <= breathe_lvl_nx[n];
                    breathe_down[n] <= breathe_down_nx[n];
                end
            end
        end
    end

    always_comb begin
        level = shadow;
        for (int n = 0; n < CHANNELS; n++)
            if (mode[n])
                level[n] = breathe_lvl[n];
    end
`else
    assign level = shadow;
`endif

    always_comb begin
        raw = '0;
        for (int n = 0; n < CHANNELS; n++)
            raw[n] = pwm_cnt < level[n];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pwm_out <= '0;
        else
            pwm_out <= enable ? (raw ^ invert) : invert;
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: scoreboard bench for led_pwm_ctrl (3 channels, 8-bit PWM).
// Expected values are queued when stimulus is issued, popped on DUT output.
module tb_led_pwm_ctrl;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_write = 1'b0;
    logic [3:0]    bus_address = '0;
    logic [31:0]   bus_wdata = '0;
    logic [31:0]   bus_rdata;
    logic [CH-1:0] pwm_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    led_pwm_ctrl #(
        .CHANNELS  (CH),
        .PWM_WIDTH (8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_write  (bus_write),
        .bus_address(bus_address),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] v = 'x;
        if (exp_q.size() != 0)
            v = exp_q.pop_front();
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_write   = 1'b1;
        bus_address = a;
        bus_wdata   = d;
        step();
        bus_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e,
                      input string tag);
        bus_address = a;
        exp_q.push_back(e);
        step();
        check(tag, bus_rdata, pop_exp());
    endtask

    // Count high samples of one channel over len cycles, optional write at wr_at.
    task automatic period(input int ch, input int len, input int wr_at,
                          input logic [3:0] wa, input logic [31:0] wd,
                          input logic [31:0] e, input string tag);
        int highs = 0;
        exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            if (i == wr_at) begin
                bus_write   = 1'b1;
                bus_address = wa;
                bus_wdata   = wd;
            end
            step();
            bus_write = 1'b0;
            if (pwm_out[ch])
                highs++;
        end
        check(tag, highs, pop_exp());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int br_exp[16] = '{0, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 0};

    initial begin
        // reset and idle
        do_reset();
        check("rst_pwm", pwm_out, 0);
        check("rst_rdata", bus_rdata, 0);
        rd(4'd0, 32'h0, "rst_ctrl");
        rd(4'd1, 32'h0, "rst_mode");
        rd(4'd2, 32'h0, "rst_invert");
        rd(4'd3, 32'h0, "rst_duty0");
        wr(4'd2, 32'h5);
        check("inv_same_cycle", pwm_out, 0);
        step();
        check("inv_idle", pwm_out, 3'b101);

        // static duty, double buffering, coincident write
        do_reset();
        wr(4'd3, 32'd64);
        wr(4'd0, 32'h1);
        period(0, 256, -1, 4'd0, 32'h0, 0, "static_p0");
        period(0, 256, -1, 4'd0, 32'h0, 64, "static_p1");
        period(0, 256, 100, 4'd3, 32'd200, 64, "glitch_free");
        period(0, 256, 255, 4'd3, 32'd0, 200, "duty200");
        period(0, 256, -1, 4'd0, 32'h0, 200, "wrap_coincident");
        period(0, 256, 10, 4'd3, 32'd255, 0, "duty0");
        period(0, 256, -1, 4'd0, 32'h0, 255, "duty255");

        // prescaler and early tick on lowered prescale
        do_reset();
        wr(4'd4, 32'd128);
        wr(4'd0, 32'h0003_0001);
        period(1, 1024, -1, 4'd0, 32'h0, 0, "presc_p0");
        period(1, 1024, -1, 4'd0, 32'h0, 512, "presc_p1");
        period(1, 261, 5, 4'd0, 32'h1, 133, "presc_lowered");
        period(1, 256, -1, 4'd0, 32'h0, 128, "presc_zero");

        // breathing
        do_reset();
        wr(4'd3, 32'd3);
        wr(4'd1, 32'h1);
`ifdef LED_PWM_BREATHE_EN
        rd(4'd1, 32'h1, "mode_rd");
        wr(4'd0, 32'h1);
        for (int p = 0; p < 16; p++)
            period(0, 256, (p == 10) ? 50 : -1, 4'd3, 32'd1, br_exp[p],
                   $sformatf("breathe_p%0d", p));
        period(0, 256, 0, 4'd1, 32'h0, 1, "mode_clear");
        period(0, 256, -1, 4'd0, 32'h0, 1, "static_after_mode");
`else
        rd(4'd1, 32'h0, "mode_rd");
        wr(4'd0, 32'h1);
        period(0, 256, -1, 4'd0, 32'h0, 0, "nobreathe_p0");
        period(0, 256, -1, 4'd0, 32'h0, 3, "nobreathe_p1");
`endif

        // read path
        wr(4'd5, 32'hFFFF_FFFF);
        rd(4'd5, 32'hFF, "duty2_rd");
        rd(4'd15, 32'h0, "unmapped_rd");
        wr(4'd0, 32'hFFFF_FFFF);
        rd(4'd0, 32'hFFFF_0001, "ctrl_rd");
        wr(4'd1, 32'hFFFF_FFFF);
`ifdef LED_PWM_BREATHE_EN
        rd(4'd1, 32'h7, "mode_mask_rd");
`else
        rd(4'd1, 32'h0, "mode_mask_rd");
`endif
        bus_write   = 1'b1;
        bus_address = 4'd2;
        bus_wdata   = 32'hFFFF_FFFA;
        exp_q.push_back(32'h2);
        step();
        bus_write = 1'b0;
        check("wr_rd_same", bus_rdata, pop_exp());
        rd(4'd2, 32'h2, "invert_rd");

        // asynchronous reset mid-period
        check("pre_reset_pwm1", pwm_out[1], 1);
        reset = 1'b1;
        #1;
        check("async_reset_pwm", pwm_out, 0);
        check("async_reset_rdata", bus_rdata, 0);
        step();
        reset = 1'b0;
        rd(4'd0, 32'h0, "ctrl_after_reset");
        step();
        step();
        check("idle_after_reset", pwm_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
